// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit:
// funct3 encodings, FSM state encoding and the special-case result constants.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011,
        F_DIV    = 3'b100,
        F_DIVU   = 3'b101,
        F_REM    = 3'b110,
        F_REMU   = 3'b111
    } funct3_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CALC   = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    // RV32 results for divide-by-zero quotient and the signed overflow quotient
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's execute stage and the
// multiply/divide unit. The core side is the master.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [ADDRESS_WIDTH-1:0] rd_in;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iteration core: turns incoming operands
// into magnitudes plus a result-sign flag, and applies the two's-complement
// correction to the finished product / quotient / remainder.
module muldiv_signfix
    import riscv_m_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              op_in,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic [DATA_WIDTH-1:0]   a_mag,
    output logic [DATA_WIDTH-1:0]   b_mag,
    output logic                    neg_in,
    input  logic [2:0]              op_q,
    input  logic                    neg_q,
    input  logic [2*DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0]   res_word
);

    function automatic logic [DATA_WIDTH-1:0] negate_word(input logic [DATA_WIDTH-1:0] v);
        return -v;
    endfunction

    function automatic logic [2*DATA_WIDTH-1:0] negate_dword(input logic [2*DATA_WIDTH-1:0] v);
        return -v;
    endfunction

    logic                    a_signed;
    logic                    b_signed;
    logic                    sa;
    logic                    sb;
    logic [2*DATA_WIDTH-1:0] full;
    logic [DATA_WIDTH-1:0]   div_word;

    // Operand magnitudes and result sign; MUL is treated as signed since its low word is sign-agnostic
    always_comb begin
        a_signed = (op_in == F_MUL) || (op_in == F_MULH) || (op_in == F_MULHSU) ||
                   (op_in == F_DIV) || (op_in == F_REM);
        b_signed = (op_in == F_MUL) || (op_in == F_MULH) ||
                   (op_in == F_DIV) || (op_in == F_REM);
        sa       = a_signed & op_a[DATA_WIDTH-1];
        sb       = b_signed & op_b[DATA_WIDTH-1];
        a_mag    = sa ? negate_word(op_a) : op_a;
        b_mag    = sb ? negate_word(op_b) : op_b;
        // remainder follows the dividend's sign; everything else is the sign product
        neg_in   = (op_in == F_REM) ? sa : (sa ^ sb);
    end

    // Final sign correction and word selection from the {hi, lo} accumulator
    always_comb begin
        full     = neg_q ? negate_dword(acc) : acc;
        div_word = ((op_q == F_DIV) || (op_q == F_DIVU)) ? acc[DATA_WIDTH-1:0]
                                                         : acc[2*DATA_WIDTH-1:DATA_WIDTH];
        if (op_q[2]) begin
            res_word = neg_q ? negate_word(div_word) : div_word;
        end else if (op_q == F_MUL) begin
            res_word = full[DATA_WIDTH-1:0];
        end else begin
            res_word = full[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide share one 2*DATA_WIDTH {hi, lo} accumulator; divide by
// zero and signed overflow bypass the iteration and finish after one edge.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] QUO_DIV0  = DATA_WIDTH'(DIV0_QUOTIENT);
    localparam logic [DATA_WIDTH-1:0] INT_MIN_W = DATA_WIDTH'(INT_MIN);
    localparam logic [DATA_WIDTH-1:0] ZERO_W    = '0;

    state_t                   state;
    logic [CNT_WIDTH-1:0]     cnt;
    logic                     done_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [ADDRESS_WIDTH-1:0] rd_out_q;

    logic [2:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     neg_q;
    logic [2*DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;

    logic [DATA_WIDTH-1:0]    a_mag;
    logic [DATA_WIDTH-1:0]    b_mag;
    logic                     neg_in;
    logic [DATA_WIDTH-1:0]    res_word;

    logic                     accept;
    logic                     is_div_in;
    logic                     div_zero;
    logic                     div_ovf;
    logic [DATA_WIDTH:0]      mul_sum;
    logic [DATA_WIDTH:0]      div_trial;
    logic [2*DATA_WIDTH-1:0]  acc_step;

    muldiv_signfix #(.DATA_WIDTH(DATA_WIDTH)) u_signfix (
        .op_in    (bus.funct3),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .neg_in   (neg_in),
        .op_q     (op_q),
        .neg_q    (neg_q),
        .acc      (acc),
        .res_word (res_word)
    );

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

    // Request acceptance and special-case detection on the live operands
    always_comb begin
        accept    = (state == ST_IDLE) && bus.start;
        is_div_in = bus.funct3[2];
        div_zero  = is_div_in && (bus.op_b == ZERO_W);
        div_ovf   = is_div_in && !bus.funct3[0] &&
                    (bus.op_a == INT_MIN_W) && (bus.op_b == ~ZERO_W);
    end

    // One radix-2 step: hi accumulates the product / holds the partial remainder, lo shifts
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, a_q} : {1'b0, ZERO_W});
        div_trial = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]} - {1'b0, b_q};
        if (op_q[2]) begin
            acc_step = div_trial[DATA_WIDTH] ? {acc[2*DATA_WIDTH-2:0], 1'b0}
                                             : {div_trial[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[DATA_WIDTH-1:1]};
        end
    end

    // Control FSM, iteration counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= (div_zero || div_ovf) ? ST_FINISH : ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    result_q <= res_word;
                    rd_out_q <= rd_q;
                    done_q   <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture at acceptance and accumulator update while iterating
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= bus.funct3;
            rd_q <= bus.rd_in;
            a_q  <= a_mag;
            b_q  <= b_mag;
            if (div_zero) begin
                // remainder = dividend, quotient = all ones, no sign fix
                acc   <= {bus.op_a, QUO_DIV0};
                neg_q <= 1'b0;
            end else if (div_ovf) begin
                acc   <= {ZERO_W, INT_MIN_W};
                neg_q <= 1'b0;
            end else begin
                // divide shifts the dividend out of lo; multiply shifts the multiplier out of lo
                acc   <= is_div_in ? {ZERO_W, a_mag} : {ZERO_W, b_mag};
                neg_q <= neg_in;
            end
        end else if (state == ST_CALC) begin
            acc <= acc_step;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, random operations against an
// arithmetic reference model, start-while-busy, back-to-back and async reset.
module tb_muldiv_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        int ia;
        int ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic scramble_inputs();
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom_range(0, 31));
    endtask

    // Present a request and return just after the sampling edge E0
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    // Edges counted until done is seen; lat = -1 if the budget runs out
    task automatic wait_done(output int lat, output logic [31:0] r, output logic [4:0] rdo);
        lat = -1;
        r   = 32'h0;
        rdo = 5'h0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                r   = bus.result;
                rdo = bus.rd_out;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r);
        int          lat;
        logic [31:0] r;
        logic [4:0]  rdo;
        logic [4:0]  rd;
        int          exp_lat;
        rd      = 5'($urandom_range(0, 31));
        exp_lat = (name.len() > 0) ? model_latency(f, a, b) : 33;
        launch(f, a, b, rd);
        wait_done(lat, r, rdo);
        total++;
        if (r !== exp_r) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", name, r, exp_r);
        end
        total++;
        if (rdo !== rd) begin
            bad++;
            $display("FAIL %s rd_out: got %0d expected %0d", name, rdo, rd);
        end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        scramble_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done: got %b expected 0", bus.done); end
        total++;
        if (bus.result !== 32'h0) begin bad++; $display("FAIL reset result: got %h expected 0", bus.result); end
        total++;
        if (bus.rd_out !== 5'h0) begin bad++; $display("FAIL reset rd_out: got %h expected 0", bus.rd_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        int          lat;
        logic [31:0] r;
        logic [4:0]  rdo;
        launch(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL mul busy: got %b expected 1", bus.busy); end
        wait_done(lat, r, rdo);
        total++;
        if (lat != 33) begin bad++; $display("FAIL mul latency: got %0d expected 33", lat); end
        total++;
        if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul result: got %h expected ffffffeb", r); end
        total++;
        if (rdo !== 5'd5) begin bad++; $display("FAIL mul rd_out: got %0d expected 5", rdo); end
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL mul done width: got %b expected 0", bus.done); end
        total++;
        if (bus.result !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul hold: got %h expected ffffffeb", bus.result); end
    endtask

    task automatic test_mulh();
        check_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        check_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        check_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        check_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        check_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'h0000_000E);
        check_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'h0000_0002);
    endtask

    task automatic test_special();
        check_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        check_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'h0000_0005);
        check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    endtask

    task automatic test_random();
        logic [31:0] corners [5];
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 5))
                0:       b = corners[$urandom_range(0, 4)];
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            check_op("random", f, a, b, model(f, a, b));
        end
    endtask

    task automatic test_start_ignored();
        int          lat;
        logic [31:0] r;
        logic [4:0]  rdo;
        int          extra;
        launch(3'd5, 32'd100, 32'd7, 5'd9);
        repeat (10) @(posedge clk);
        #1;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        bus.rd_in  = 5'd3;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, r, rdo);
        total++;
        if (lat != 22) begin bad++; $display("FAIL ignored latency: got %0d expected 22", lat); end
        total++;
        if (r !== 32'h0000_000E) begin bad++; $display("FAIL ignored result: got %h expected 0000000e", r); end
        total++;
        if (rdo !== 5'd9) begin bad++; $display("FAIL ignored rd_out: got %0d expected 9", rdo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL ignored queued: got %0d done pulses expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] r;
        logic [4:0]  rdo;
        launch(3'd0, 32'd12, 32'd11, 5'd1);
        wait_done(lat, r, rdo);
        total++;
        if (r !== 32'd132) begin bad++; $display("FAIL b2b first result: got %h expected 00000084", r); end
        // still inside the done cycle: present the next request
        bus.funct3 = 3'd6;
        bus.op_a   = 32'hFFFF_FF9C;
        bus.op_b   = 32'd7;
        bus.rd_in  = 5'd0;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b busy: got %b expected 1", bus.busy); end
        wait_done(lat, r, rdo);
        total++;
        if (lat != 33) begin bad++; $display("FAIL b2b latency: got %0d expected 33", lat); end
        total++;
        if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL b2b second result: got %h expected fffffffe", r); end
        total++;
        if (rdo !== 5'd0) begin bad++; $display("FAIL b2b rd_out: got %0d expected 0", rdo); end
    endtask

    task automatic test_reset_mid();
        int extra;
        launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset done: got %b expected 0", bus.done); end
        total++;
        if (bus.result !== 32'h0) begin bad++; $display("FAIL midreset result: got %h expected 0", bus.result); end
        total++;
        if (bus.rd_out !== 5'h0) begin bad++; $display("FAIL midreset rd_out: got %h expected 0", bus.rd_out); end
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL midreset done after abort: got %0d pulses expected 0", extra); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul_basic();
        test_mulh();
        test_div();
        test_special();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the single-cycle core's execute/writeback path.
- Consumes the register file's two read-port operands (RD1/RD2) when the decoder flags an M-extension op.
- Produces a result plus destination-register tag that drive the register file write port (WD3/AD3/WE3).
- Core stalls on busy; done is the write-enable pulse.

Parameters:
- DATA_WIDTH, 32, operand/result width
- ADDRESS_WIDTH, 5, register tag width
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when busy=0
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  DATA_WIDTH  rs1 value (from RD1)
- op_b  input  DATA_WIDTH  rs2 value (from RD2)
- rd_in  input  ADDRESS_WIDTH  destination register
- busy  output  1  operation in progress; core stalls PC
- done  output  1  one-cycle pulse; result/rd_out valid; drives WE3
- result  output  DATA_WIDTH  drives WD3
- rd_out  output  ADDRESS_WIDTH  drives AD3

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Reset mid-operation aborts it; no done follows.
- FSM states: IDLE, CALC, FINISH. busy = (state != IDLE), combinational from state.
- IDLE, start=1 at edge E0: latch funct3 and rd_in. Latch operand magnitudes (abs for signed operands; MULHSU treats only op_a as signed). Record result sign. Counter=0.
- Normal path after E0: go to CALC.
- Special path after E0, straight to FINISH:
  - divide by zero: DIV/DIVU quotient = all-ones; REM/REMU remainder = op_a.
  - signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC: one radix-2 step per edge.
  - Multiply: shift-add into 2*DATA_WIDTH accumulator.
  - Divide: restoring, 1 quotient bit per step.
  - Counter increments; the step at counter=31 (edge E32) moves to FINISH.
- FINISH (edge E33 normal, E1 special): apply sign correction, register result and rd_out, done=1, go to IDLE.
  - MUL: low word. MULH/MULHSU/MULHU: high word, negated 64-bit when sign set.
  - Quotient: negative if operand signs differ (signed ops). Remainder: takes sign of op_a.
- done is 0 in every other cycle. result/rd_out hold their value until the next FINISH.
- Latency: done visible after 33 edges (normal) or 1 edge (special), counted from the sampling edge.
- start while busy=1: ignored, no queuing.
- start in the cycle done=1: accepted (state is already IDLE). Back-to-back throughput is one op per 34 cycles.
- rd_out=0 with done=1 is legal; the register file discards writes to x0.
- funct3 is decoded only at E0; input changes during CALC have no effect.

Decomposition:
- Package riscv_m_pkg:
  - funct3 enum: MUL..REMU
  - FSM state enum
  - constants: DIV0_QUOTIENT (all-ones), INT_MIN (0x80000000)
- One natural sub-module: muldiv_signfix. Combinational operand abs/sign capture and final two's-complement result negation, shared by the multiply and divide paths.
- Iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> busy for 33 edges, then done=1 one cycle, result=0xFFFFFFEB, rd_out=5.
- op_a=op_b=0xFFFFFFFF -> MULHU result 0xFFFFFFFE; MULH result 0x00000000; MULHSU result 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
- DIV 5/0 -> done after 1 edge, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- start with new operands pulsed at counter=10 -> ignored, first result unchanged. start held high in the done cycle -> second op accepted, busy stays 1, second done 33 edges later.
- rst asserted at counter=10 -> busy=0, done=0, result=0 without waiting for a clock edge; no done pulse in the following 40 cycles.
